mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have the ports below, clock and reset first; one clock, synchronous active-low reset.
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- valid_MEM  in  1  instruction in MEM stage is valid
- memWrite_MEM  in  1  store request
- resultSrc_MEM  in  2  2'b01 = load
- funct3_MEM  in  3  access size/sign
- ALUResult_MEM  in  32  byte address
- storeOut_MEM  in  32  store data, low-aligned
- bus_req  out  1  data-bus request, registered
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_ack  in  1  bus completion
- bus_rdata  in  32  read word, valid with bus_ack
- stall_MEM  out  1  hold EX/MEM register and earlier stages
- readData_MEM  out  32  extended load result, registered
- misaligned_MEM  out  1  misaligned access flag

Function
REQ-002 SHALL treat access = valid_MEM & (memWrite_MEM | resultSrc_MEM==2'b01); memWrite has priority.
REQ-003 SHALL implement FSM IDLE, REQ, DONE.
REQ-004 IDLE: access and legal -> REQ; access and illegal -> DONE; else stay.
REQ-005 REQ: bus_req=1, bus_we/addr/wdata/be held stable; bus_ack -> DONE, else stay.
REQ-006 DONE: unconditionally -> IDLE; never reissues the still-presented instruction.
REQ-007 stall_MEM SHALL be 1 combinationally in IDLE with access present, and in REQ; 0 in DONE.
REQ-008 Minimum latency 3 cycles: cycle 0 IDLE (stall), cycle 1 REQ with same-cycle ack, cycle 2 DONE.
REQ-009 bus_ack outside REQ SHALL be ignored.
REQ-010 Stores: SB(000) be=1<<addr[1:0], wdata=byte x4; SH(001) be=addr[1]?1100:0011, wdata=half x2; SW(010) be=1111.
REQ-011 Loads: LB(000)/LH(001) sign-extend, LBU(100)/LHU(101) zero-extend selected lane; LW(010) whole word; captured into readData_MEM on ack.
REQ-012 funct3 011/110/111 SHALL be illegal: no bus transaction, readData_MEM=0, misaligned_MEM=0.
REQ-013 Illegal/misaligned path SHALL leave readData_MEM at 0 and the bus untouched.

Reset
REQ-014 rst_n low at an edge SHALL force IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, readData_MEM=0, misaligned_MEM=0.
REQ-015 Reset mid-REQ SHALL drop bus_req at that edge; a later ack SHALL be ignored.

Configuration
REQ-016 With LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL be illegal, and misaligned_MEM=1 for the DONE cycle only.
REQ-017 Without LSU_MISALIGN_TRAP_EN: misaligned_MEM tied 0; halfword lanes use addr[1] only, word ignores addr[1:0]; bus access always performed.

Structure
REQ-018 Shared package SHALL hold funct3 encodings (LB..LHU, SB..SW), RESULTSRC_LOAD constant, FSM state enum.
REQ-019 Load lane select and extension SHALL be a combinational sub-module load_extend.

Verification
REQ-020 LW addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF -> readData_MEM=0xDEADBEEF; stall high 3 cycles.
REQ-021 LB addr 0x103, rdata 0x80FF_0000 -> readData_MEM=0xFFFFFF80; LBU same -> 0x00000080.
REQ-022 SH addr 0x102, storeOut 0x0000ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x100, bus_we=1.
REQ-023 Macro on, LW addr 0x101 -> no bus_req, misaligned_MEM=1 one cycle, stall 1 cycle; macro off -> bus access at 0x100.
REQ-024 rst_n low during REQ with ack withheld, ack after reset -> bus_req 0, IDLE, readData_MEM=0.
REQ-025 Back-to-back SW 0x10 then LW 0x10 with ack delayed 4 cycles -> exactly two bus transactions, no reissue.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - funct3 access-size encodings for loads (LB..LHU) and stores (SB..SW)
//   - RESULTSRC_LOAD, the resultSrc value that marks a load
//   - FSM state enum
//   - helpers for funct3 legality, byte-enable and store-lane generation
// -----------------------------------------------------------------------------
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // 011, 110 and 111 encode no access size and never reach the bus.
    function automatic logic f3_is_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b011:  ok = 1'b0;
            3'b110:  ok = 1'b0;
            3'b111:  ok = 1'b0;
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Byte enables from access size (funct3[1:0]) and low address bits.
    function automatic logic [3:0] lane_enables(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate low-aligned store data across every lane it could occupy.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{data[7:0]}};
            2'b01:   w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational lane select and sign/zero extension of a bus read word.
// Ports:
//   i_funct3  [2:0]  load type (LB/LH/LW/LBU/LHU)
//   i_addr_lo [1:0]  low byte-address bits of the load
//   i_rdata   [31:0] raw word from the bus
//   o_data    [31:0] extended load result (0 for non-load encodings)
// -----------------------------------------------------------------------------
module load_extend
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/halfword, then extend according to funct3.
    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LW:   o_data = i_rdata;
            F3_LBU:  o_data = {24'h000000, w_byte};
            F3_LHU:  o_data = {16'h0000, w_half};
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// MEM-stage load/store unit: turns a load/store in the MEM stage into one
// data-bus transaction, stalling the pipeline until it completes.
// FSM: IDLE -> REQ (bus_req high until bus_ack) -> DONE (stall released) -> IDLE.
// Illegal accesses go IDLE -> DONE without touching the bus.
// Option: define LSU_MISALIGN_TRAP_EN to treat misaligned halfword/word
// accesses as illegal and flag misaligned_MEM during their DONE cycle.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   valid_MEM, memWrite_MEM,
//   resultSrc_MEM, funct3_MEM,
//   ALUResult_MEM, storeOut_MEM    instruction presented by the MEM stage
//   bus_req/we/addr/wdata/be       registered data-bus request
//   bus_ack, bus_rdata             bus completion and read data
//   stall_MEM                      holds EX/MEM and earlier stages
//   readData_MEM                   registered extended load result
//   misaligned_MEM                 misaligned-access flag (DONE cycle only)
// -----------------------------------------------------------------------------
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_MEM,
    input  logic        memWrite_MEM,
    input  logic [1:0]  resultSrc_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [31:0] ALUResult_MEM,
    input  logic [31:0] storeOut_MEM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall_MEM,
    output logic [31:0] readData_MEM,
    output logic        misaligned_MEM
);

    lsu_state_e  r_state;
    lsu_state_e  w_next_state;

    logic        w_access;
    logic        w_misal;
    logic        w_legal;
    logic        w_start_bus;
    logic        w_start_illegal;
    logic        w_capture;
    logic [31:0] w_load_data;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;
    logic        r_is_load;
    logic [31:0] r_read_data;
    logic        r_misaligned;

    // memWrite wins over a load encoding in resultSrc.
    assign w_access = valid_MEM & (memWrite_MEM | (resultSrc_MEM == RESULTSRC_LOAD));

    // Misalignment detection; only meaningful for legal funct3 encodings.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        case (funct3_MEM[1:0])
            2'b01:   w_misal = ALUResult_MEM[0];
            2'b10:   w_misal = (ALUResult_MEM[1:0] != 2'b00);
            default: w_misal = 1'b0;
        endcase
        w_misal = w_misal & f3_is_legal(funct3_MEM);
`else
        w_misal = 1'b0;
`endif
        w_legal = f3_is_legal(funct3_MEM) & ~w_misal;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_next_state = w_legal ? ST_REQ : ST_DONE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: stall and datapath strobes.
    always_comb begin
        stall_MEM       = 1'b0;
        w_start_bus     = 1'b0;
        w_start_illegal = 1'b0;
        w_capture       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall_MEM       = w_access;
                w_start_bus     = w_access & w_legal;
                w_start_illegal = w_access & ~w_legal;
            end
            ST_REQ: begin
                stall_MEM = 1'b1;
                w_capture = bus_ack & r_is_load;
            end
            ST_DONE: stall_MEM = 1'b0;
            default: stall_MEM = 1'b0;
        endcase
    end

    load_extend u_load_extend (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .i_rdata   (bus_rdata),
        .o_data    (w_load_data)
    );

    // Bus request registers, latched once on entry to REQ so they stay stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_wdata <= 32'h0000_0000;
            r_bus_be    <= 4'b0000;
            r_addr_lo   <= 2'b00;
            r_funct3    <= 3'b000;
            r_is_load   <= 1'b0;
        end else begin
            r_bus_req <= (w_next_state == ST_REQ);
            if (w_start_bus) begin
                r_bus_we    <= memWrite_MEM;
                r_bus_addr  <= {ALUResult_MEM[31:2], 2'b00};
                r_bus_wdata <= memWrite_MEM ? store_lanes(funct3_MEM, storeOut_MEM) : 32'h0000_0000;
                r_bus_be    <= lane_enables(funct3_MEM, ALUResult_MEM[1:0]);
                r_addr_lo   <= ALUResult_MEM[1:0];
                r_funct3    <= funct3_MEM;
                r_is_load   <= ~memWrite_MEM;
            end else begin
                r_bus_we <= r_bus_we;
            end
        end
    end

    // Load result and misalignment flag; illegal accesses clear the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_read_data  <= 32'h0000_0000;
            r_misaligned <= 1'b0;
        end else begin
            if (w_start_illegal) begin
                r_read_data <= 32'h0000_0000;
            end else if (w_capture) begin
                r_read_data <= w_load_data;
            end else begin
                r_read_data <= r_read_data;
            end
            r_misaligned <= w_start_illegal & w_misal;
        end
    end

    assign bus_req        = r_bus_req;
    assign bus_we         = r_bus_we;
    assign bus_addr       = r_bus_addr;
    assign bus_wdata      = r_bus_wdata;
    assign bus_be         = r_bus_be;
    assign readData_MEM   = r_read_data;
    assign misaligned_MEM = r_misaligned;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Self-checking bench for mem_stage_lsu: directed scenarios followed by
// randomized loads/stores against a behavioural model of the access rules.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_MEM;
    logic        memWrite_MEM;
    logic [1:0]  resultSrc_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] ALUResult_MEM;
    logic [31:0] storeOut_MEM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_MEM;
    logic [31:0] readData_MEM;
    logic        misaligned_MEM;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int n_txn  = 0;
    logic prev_req = 1'b0;
    logic [31:0] exp_rd = 32'h0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_MEM      (valid_MEM),
        .memWrite_MEM   (memWrite_MEM),
        .resultSrc_MEM  (resultSrc_MEM),
        .funct3_MEM     (funct3_MEM),
        .ALUResult_MEM  (ALUResult_MEM),
        .storeOut_MEM   (storeOut_MEM),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_be         (bus_be),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata),
        .stall_MEM      (stall_MEM),
        .readData_MEM   (readData_MEM),
        .misaligned_MEM (misaligned_MEM)
    );

    // Count bus transactions as rising edges of bus_req.
    always @(negedge clk) begin
        if (bus_req && !prev_req) n_txn++;
        prev_req = bus_req;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    endfunction

    function automatic bit f3_ok(input logic [2:0] f3);
        return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    function automatic bit is_misal(input logic [2:0] f3, input logic [31:0] addr);
        return TRAP && f3_ok(f3) && ((addr % size_bytes(f3)) != 0);
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz = size_bytes(f3);
        if (sz == 1) return 32'(1 << addr[1:0]);
        if (sz == 2) return 32'(3 << (2 * addr[1]));
        return 32'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = size_bytes(f3);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int sz = size_bytes(f3);
        int off;
        logic [31:0] v;
        if (sz == 4) return rdata;
        off = (sz == 2) ? 2 * addr[1] : int'(addr[1:0]);
        v = (rdata >> (8 * off)) & 32'((1 << (8 * sz)) - 1);
        if (!f3[2] && v >= 32'(1 << (8 * sz - 1))) v = v - 32'(1 << (8 * sz));
        return v;
    endfunction

    // ---------------- stimulus ----------------
    // Present one access, act as bus slave with the given ack delay, and check
    // everything up to and including the DONE cycle. Entered and left at a negedge.
    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] rdata, input int delay);
        bit legal = f3_ok(f3) && !is_misal(f3, addr);
        int stall_cyc = 0;
        int req_cyc = 0;
        int txn0 = n_txn;
        bit done = 1'b0;
        valid_MEM     = 1'b1;
        memWrite_MEM  = st;
        resultSrc_MEM = st ? 2'($urandom_range(0, 3)) : 2'b01;
        funct3_MEM    = f3;
        ALUResult_MEM = addr;
        storeOut_MEM  = sdata;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (!stall_MEM) begin
                done = 1'b1;
                break;
            end
            stall_cyc++;
            if (bus_req) begin
                check_eq("bus_addr", bus_addr, {addr[31:2], 2'b00});
                check_eq("bus_we", 32'(bus_we), 32'(st));
                if (st) begin
                    check_eq("bus_be", 32'(bus_be), model_be(f3, addr));
                    check_eq("bus_wdata", bus_wdata, model_wdata(f3, sdata));
                end
                bus_ack   = (req_cyc == delay);
                bus_rdata = (req_cyc == delay) ? rdata : $urandom();
                req_cyc++;
            end else begin
                bus_ack   = 1'($urandom_range(0, 1));
                bus_rdata = $urandom();
            end
            @(negedge clk);
        end
        check_eq("done_reached", 32'(done), 32'd1);
        if (!legal) exp_rd = 32'h0;
        else if (!st) exp_rd = model_load(f3, addr, rdata);
        check_eq("stall_cycles", stall_cyc, legal ? delay + 2 : 1);
        check_eq("req_cycles", req_cyc, legal ? delay + 1 : 0);
        check_eq("txn_count", n_txn - txn0, legal ? 1 : 0);
        check_eq("bus_req_done", 32'(bus_req), 32'd0);
        check_eq("readData", readData_MEM, exp_rd);
        check_eq("misaligned", 32'(misaligned_MEM), 32'(is_misal(f3, addr)));
        bus_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
    endtask

    // A cycle with no memory access: nothing may move, stray acks ignored.
    task automatic idle_cycle();
        valid_MEM     = 1'($urandom_range(0, 1));
        memWrite_MEM  = 1'b0;
        resultSrc_MEM = 2'($urandom_range(0, 2));
        if (resultSrc_MEM == 2'b01) resultSrc_MEM = 2'b11;
        bus_ack       = 1'($urandom_range(0, 1));
        bus_rdata     = $urandom();
        #1;
        check_eq("idle_stall", 32'(stall_MEM), 32'd0);
        check_eq("idle_req", 32'(bus_req), 32'd0);
        check_eq("idle_misal", 32'(misaligned_MEM), 32'd0);
        check_eq("idle_rd", readData_MEM, exp_rd);
        @(negedge clk);
    endtask

    initial begin
        int t0;
        bit st;
        logic [2:0] f3;
        rst_n = 1'b0;
        valid_MEM = 1'b0;
        memWrite_MEM = 1'b0;
        resultSrc_MEM = 2'b00;
        funct3_MEM = 3'b000;
        ALUResult_MEM = 32'h0;
        storeOut_MEM = 32'h0;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_req", 32'(bus_req), 32'd0);
        check_eq("rst_we", 32'(bus_we), 32'd0);
        check_eq("rst_be", 32'(bus_be), 32'd0);
        check_eq("rst_addr", bus_addr, 32'd0);
        check_eq("rst_wdata", bus_wdata, 32'd0);
        check_eq("rst_rd", readData_MEM, 32'd0);
        check_eq("rst_misal", 32'(misaligned_MEM), 32'd0);
        check_eq("rst_stall", 32'(stall_MEM), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios.
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        check_eq("lw_deadbeef", readData_MEM, 32'hDEADBEEF);
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
        check_eq("lb_sext", readData_MEM, 32'hFFFF_FF80);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 2);
        check_eq("lbu_zext", readData_MEM, 32'h0000_0080);
        do_access(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 0);
        do_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 1);
        idle_cycle();
        do_access(1'b0, 3'b011, 32'h200, 32'h0, 32'h5555_5555, 0);
        idle_cycle();

        // Reset in the middle of REQ with the ack withheld.
        valid_MEM = 1'b1; memWrite_MEM = 1'b0; resultSrc_MEM = 2'b01;
        funct3_MEM = 3'b010; ALUResult_MEM = 32'h300; bus_ack = 1'b0;
        @(negedge clk);
        #1;
        check_eq("pre_rst_req", 32'(bus_req), 32'd1);
        rst_n = 1'b0; valid_MEM = 1'b0;
        @(negedge clk);
        #1;
        exp_rd = 32'h0;
        check_eq("midrst_req", 32'(bus_req), 32'd0);
        check_eq("midrst_stall", 32'(stall_MEM), 32'd0);
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        check_eq("late_ack_req", 32'(bus_req), 32'd0);
        check_eq("late_ack_rd", readData_MEM, 32'd0);
        bus_ack = 1'b0;
        @(negedge clk);

        // Back-to-back SW then LW with slow acks.
        t0 = n_txn;
        do_access(1'b1, 3'b010, 32'h10, 32'h0BAD_CAFE, 32'h0, 4);
        do_access(1'b0, 3'b010, 32'h10, 32'h0, 32'h0BAD_CAFE, 4);
        check_eq("b2b_txns", n_txn - t0, 2);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if (st && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
            do_access(st, f3, $urandom(), $urandom(), $urandom(), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
